// File: rtl/watch_time_counter_if.sv
// Bundle of control inputs and time/tick outputs exchanged between the
// watch control logic (master) and the time-of-day counter (slave).
interface watch_time_counter_if #(
  parameter int unsigned SEC_BIT  = 6,
  parameter int unsigned MIN_BIT  = 6,
  parameter int unsigned HOUR_BIT = 6
);
  logic                i_sec_tick;
  logic                i_run_en;
  logic                i_clear;
  logic                i_set_mode;
  logic                i_set_sel;
  logic                i_set_inc;
  logic [SEC_BIT-1:0]  o_sec;
  logic [MIN_BIT-1:0]  o_min;
  logic [HOUR_BIT-1:0] o_hour;
  logic                o_min_tick;
  logic                o_hour_tick;
  logic                o_day_tick;
  logic                o_set_active;

  modport master (
    output i_sec_tick, i_run_en, i_clear, i_set_mode, i_set_sel, i_set_inc,
    input  o_sec, o_min, o_hour, o_min_tick, o_hour_tick, o_day_tick, o_set_active
  );

  modport slave (
    input  i_sec_tick, i_run_en, i_clear, i_set_mode, i_set_sel, i_set_inc,
    output o_sec, o_min, o_hour, o_min_tick, o_hour_tick, o_day_tick, o_set_active
  );
endinterface

// File: rtl/watch_time_counter.sv
// 24-hour time-of-day counter driven by a 1 Hz tick, with a RUN/SET
// machine for manual minute/hour adjustment and rollover carry pulses.
module watch_time_counter #(
  parameter int unsigned SEC_BIT  = 6,
  parameter int unsigned MIN_BIT  = 6,
  parameter int unsigned HOUR_BIT = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  watch_time_counter_if.slave   bus
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;

  localparam logic [SEC_BIT-1:0]  SEC_MAX  = SEC_BIT'(59);
  localparam logic [MIN_BIT-1:0]  MIN_MAX  = MIN_BIT'(59);
  localparam logic [HOUR_BIT-1:0] HOUR_MAX = HOUR_BIT'(23);

  logic [0:0]          state_q, state_d;
  logic [SEC_BIT-1:0]  sec_q, sec_d;
  logic [MIN_BIT-1:0]  min_q, min_d;
  logic [HOUR_BIT-1:0] hour_q, hour_d;
  logic                min_tick_q, min_tick_d;
  logic                hour_tick_q, hour_tick_d;
  logic                day_tick_q, day_tick_d;

  // Wrap flags use >= so any unreachable out-of-range value rolls back to 0.
  logic sec_wrap, min_wrap, hour_wrap;
  assign sec_wrap  = (sec_q  >= SEC_MAX);
  assign min_wrap  = (min_q  >= MIN_MAX);
  assign hour_wrap = (hour_q >= HOUR_MAX);

  // Next-state: clear, then FSM transition, then SET increment or RUN counting.
  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;

    if (bus.i_clear) begin
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (state_q == ST_RUN && bus.i_set_mode) begin
      state_d = ST_SET;
      sec_d   = '0;
    end else if (state_q == ST_SET && !bus.i_set_mode) begin
      state_d = ST_RUN;
    end else if (state_q == ST_SET) begin
      sec_d = '0;
      if (bus.i_set_inc) begin
        if (bus.i_set_sel) begin
          hour_d = hour_wrap ? '0 : hour_q + 1'b1;
        end else begin
          min_d = min_wrap ? '0 : min_q + 1'b1;
        end
      end
    end else if (bus.i_sec_tick && bus.i_run_en) begin
      if (sec_wrap) begin
        sec_d      = '0;
        min_tick_d = 1'b1;
        if (min_wrap) begin
          min_d       = '0;
          hour_tick_d = 1'b1;
          if (hour_wrap) begin
            hour_d     = '0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + 1'b1;
          end
        end else begin
          min_d = min_q + 1'b1;
        end
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
    end
  end

  assign bus.o_sec        = sec_q;
  assign bus.o_min        = min_q;
  assign bus.o_hour       = hour_q;
  assign bus.o_min_tick   = min_tick_q;
  assign bus.o_hour_tick  = hour_tick_q;
  assign bus.o_day_tick   = day_tick_q;
  assign bus.o_set_active = (state_q == ST_SET);

endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter: directed scenarios followed by
// randomized stimulus, checked every cycle against a time-of-day model.
module tb_watch_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;

  watch_time_counter_if #(.SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(6)) bus ();

  watch_time_counter #(.SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int min;
    int hour;
    bit mt;
    bit ht;
    bit dt;
    bit sa;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // Reference model: time held as h/m/s, RUN counting done on seconds-of-day.
  int  mh = 0, mm = 0, ms = 0;
  bit  mset = 1'b0;

  task automatic model(input bit rst, tick, run, clr, mode, sel, inc, output exp_t e);
    int t;
    e.mt = 1'b0;
    e.ht = 1'b0;
    e.dt = 1'b0;
    if (rst) begin
      mh = 0; mm = 0; ms = 0; mset = 1'b0;
    end else if (clr) begin
      mh = 0; mm = 0; ms = 0;
    end else if (mode != mset) begin
      mset = mode;
      if (mode) ms = 0;
    end else if (mset) begin
      if (inc) begin
        if (sel) mh = (mh + 1) % 24;
        else     mm = (mm + 1) % 60;
      end
    end else if (tick && run) begin
      t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      mh = t / 3600;
      mm = (t / 60) % 60;
      ms = t % 60;
      e.mt = (ms == 0);
      e.ht = (ms == 0) && (mm == 0);
      e.dt = (t == 0);
    end
    e.sec  = ms;
    e.min  = mm;
    e.hour = mh;
    e.sa   = mset;
  endtask

  task automatic step(input bit rst, tick, run, clr, mode, sel, inc);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.i_sec_tick = tick;
    bus.i_run_en   = run;
    bus.i_clear    = clr;
    bus.i_set_mode = mode;
    bus.i_set_sel  = sel;
    bus.i_set_inc  = inc;
    model(rst, tick, run, clr, mode, sel, inc, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_mis++;
      $display("FAIL cyc=%0d %s: got %0d expected %0d", cyc, name, act, expv);
    end
  endtask

  // Monitor: one expected record per clocked cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        chk("o_sec",        int'(bus.o_sec),        e.sec);
        chk("o_min",        int'(bus.o_min),        e.min);
        chk("o_hour",       int'(bus.o_hour),       e.hour);
        chk("o_min_tick",   int'(bus.o_min_tick),   int'(e.mt));
        chk("o_hour_tick",  int'(bus.o_hour_tick),  int'(e.ht));
        chk("o_day_tick",   int'(bus.o_day_tick),   int'(e.dt));
        chk("o_set_active", int'(bus.o_set_active), int'(e.sa));
      end
    end
  end

  task automatic idle(input bit mode);
    step(1'b0, 1'b0, 1'b1, 1'b0, mode, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n, input bit run);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, run, 1'b0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1'b0);
    end
  endtask

  task automatic set_incs(input bit sel, input int n, input bit tick);
    for (int i = 0; i < n; i++) step(1'b0, tick, 1'b1, 1'b0, 1'b1, sel, 1'b1);
  endtask

  initial begin
    bit r_mode;
    reset          = 1'b1;
    bus.i_sec_tick = 1'b0;
    bus.i_run_en   = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_set_mode = 1'b0;
    bus.i_set_sel  = 1'b0;
    bus.i_set_inc  = 1'b0;

    // Reset state, then 60 ticks: one minute carry.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(60, 1'b1);

    // Preload 23:59 in SET, back to RUN, count to 23:59:58 then roll the day.
    idle(1'b1);
    set_incs(1'b1, (23 - mh + 24) % 24, 1'b0);
    set_incs(1'b0, (59 - mm + 60) % 60, 1'b0);
    idle(1'b0);
    ticks(58, 1'b1);
    ticks(2, 1'b1);
    idle(1'b0);

    // Hold with run disabled, then resume.
    ticks(10, 1'b0);
    ticks(5, 1'b1);

    // SET hours: 25 increments with ticks present.
    idle(1'b1);
    set_incs(1'b1, 25, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Reset while in SET at 12:34:00.
    idle(1'b1);
    set_incs(1'b1, (12 - mh + 24) % 24, 1'b0);
    set_incs(1'b0, (34 - mm + 60) % 60, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

    // Clear coincident with a minute-carry tick at 00:00:59.
    ticks(59, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Randomized traffic.
    r_mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit rr, rc;
      rr = ($urandom_range(0, 299) == 0);
      rc = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 63) == 0) r_mode = ~r_mode;
      if (rr) r_mode = 1'b0;
      step(rr, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), rc,
           r_mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
